// File: rtl/subneg_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : subneg_run_ctrl_if
// Description : Host program-load handshake and memory write bus shared
//               between the host (master) and the run controller (slave).
//               Signals:
//                 load_valid_i / load_addr_i / load_data_i  host write request
//                 load_ready_o                             request accepted
//                 mem_we_o / mem_addr_o / mem_wdata_o      memory write port
// Revision    : 1.0  initial release
// ============================================================================
interface subneg_run_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 5
);
    logic              load_valid_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic [DATA_W-1:0] load_data_i;
    logic              load_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;

    // Host side: issues write requests, observes acceptance and the memory bus.
    modport master (
        output load_valid_i, load_addr_i, load_data_i,
        input  load_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Controller side.
    modport slave (
        input  load_valid_i, load_addr_i, load_data_i,
        output load_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/subneg_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : subneg_run_ctrl
// Description : Run/step/halt sequencer for the 5-bit SUBNEG core. Issues the
//               fetch/operand-read/execute phase strobes and arbitrates the
//               single memory port between execution and host program load
//               (loads only while halted). Reports breakpoint, fault and a
//               saturating retired-instruction count.
// Ports       : clk, rst_n (sync, active-low)
//               run_i (level), step_i (pulse), halt_i (pulse)
//               bp_en_i, bp_addr_i    breakpoint control
//               pc_i                  core PC
//               bus                   load handshake + memory write port
//               fetch_en_o, read_en_o, exec_en_o   one-hot phase strobes
//               running_o, bp_hit_o, fault_o, icount_o   status
// Revision    : 1.0  initial release
// ============================================================================
module subneg_run_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int MEM_DEPTH = 22,
    parameter int DATA_W    = 5,
    parameter int CNT_W     = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              run_i,
    input  wire logic              step_i,
    input  wire logic              halt_i,
    input  wire logic              bp_en_i,
    input  wire logic [ADDR_W-1:0] bp_addr_i,
    input  wire logic [ADDR_W-1:0] pc_i,
    subneg_run_ctrl_if.slave       bus,
    output logic                   fetch_en_o,
    output logic                   read_en_o,
    output logic                   exec_en_o,
    output logic                   running_o,
    output logic                   bp_hit_o,
    output logic                   fault_o,
    output logic [CNT_W-1:0]       icount_o
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_check = 3'd1;
    localparam logic [2:0] c_fetch = 3'd2;
    localparam logic [2:0] c_oper  = 3'd3;
    localparam logic [2:0] c_exec  = 3'd4;

    // An instruction occupies three words, so the last legal start PC is
    // MEM_DEPTH-3.
    localparam logic [ADDR_W-1:0] c_max_pc = ADDR_W'(MEM_DEPTH - 3);
    localparam logic [ADDR_W:0]   c_depth  = (ADDR_W + 1)'(MEM_DEPTH);

    logic [2:0]       state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic             single_q, single_d;
    logic             suppress_q, suppress_d;
    logic             retired_q, retired_d;
    logic             step_defer_q, step_defer_d;
    logic             bp_hit_q, bp_hit_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] icount_q, icount_d;

    logic w_ready;
    logic w_start_req;
    logic w_stop;

    assign w_ready          = (state_q == c_idle);
    assign bus.load_ready_o = w_ready;
    assign bus.mem_we_o     = bus.load_valid_i & w_ready
                            & ({1'b0, bus.load_addr_i} < c_depth);
    assign bus.mem_addr_o   = bus.load_addr_i;
    assign bus.mem_wdata_o  = bus.load_data_i;

    // A step pulse that collided with a host load is remembered so the start
    // is only deferred, not lost; run_i is a level and needs no memory.
    assign w_start_req = run_i | step_i | step_defer_q;
    assign w_stop      = halt_pend_q | (single_q & retired_q) | (~single_q & ~run_i);

    always_comb begin
        state_d      = state_q;
        halt_pend_d  = halt_pend_q;
        single_d     = single_q;
        suppress_d   = suppress_q;
        retired_d    = retired_q;
        step_defer_d = step_defer_q;
        bp_hit_d     = bp_hit_q;
        fault_d      = fault_q;
        icount_d     = icount_q;

        if ((state_q != c_idle) && halt_i) begin
            halt_pend_d = 1'b1;
        end

        case (state_q)
            c_idle: begin
                if (fault_q || halt_i) begin
                    step_defer_d = 1'b0;
                end else if (w_start_req) begin
                    if (bus.load_valid_i) begin
                        step_defer_d = step_i | step_defer_q;
                    end else begin
                        state_d      = c_check;
                        suppress_d   = 1'b1;
                        single_d     = step_i | step_defer_q;
                        retired_d    = 1'b0;
                        bp_hit_d     = 1'b0;
                        step_defer_d = 1'b0;
                        halt_pend_d  = 1'b0;
                    end
                end
            end
            c_check: begin
                suppress_d = 1'b0;
                if (pc_i > c_max_pc) begin
                    fault_d     = 1'b1;
                    state_d     = c_idle;
                    halt_pend_d = 1'b0;
                end else if (bp_en_i && (pc_i == bp_addr_i) && !suppress_q) begin
                    bp_hit_d    = 1'b1;
                    state_d     = c_idle;
                    halt_pend_d = 1'b0;
                end else if (w_stop) begin
                    state_d     = c_idle;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = c_fetch;
                end
            end
            c_fetch: state_d = c_oper;
            c_oper:  state_d = c_exec;
            c_exec: begin
                state_d   = c_check;
                retired_d = 1'b1;
                if (icount_q != {CNT_W{1'b1}}) begin
                    icount_d = icount_q + 1'b1;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= c_idle;
            halt_pend_q  <= 1'b0;
            single_q     <= 1'b0;
            suppress_q   <= 1'b0;
            retired_q    <= 1'b0;
            step_defer_q <= 1'b0;
            bp_hit_q     <= 1'b0;
            fault_q      <= 1'b0;
            icount_q     <= '0;
        end else begin
            state_q      <= state_d;
            halt_pend_q  <= halt_pend_d;
            single_q     <= single_d;
            suppress_q   <= suppress_d;
            retired_q    <= retired_d;
            step_defer_q <= step_defer_d;
            bp_hit_q     <= bp_hit_d;
            fault_q      <= fault_d;
            icount_q     <= icount_d;
        end
    end

    assign fetch_en_o = (state_q == c_fetch);
    assign read_en_o  = (state_q == c_oper);
    assign exec_en_o  = (state_q == c_exec);
    assign running_o  = (state_q != c_idle);
    assign bp_hit_o   = bp_hit_q;
    assign fault_o    = fault_q;
    assign icount_o   = icount_q;

endmodule
`default_nettype wire

// File: tb/tb_subneg_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_subneg_run_ctrl
// Description : Self-checking bench for subneg_run_ctrl. A table of per-cycle
//               vectors covers load handling and free-run; hand-written
//               sequences cover step, breakpoint, fault, halt and reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_subneg_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_i, step_i, halt_i, bp_en_i;
    logic [4:0] bp_addr_i;
    logic       fetch_en, read_en, exec_en, running, bp_hit, fault;
    logic [7:0] icount;

    // Core PC model: advances on the edge that ends EXEC, can be preset.
    logic       pc_set;
    logic [4:0] pc_set_val;
    logic [4:0] pc_q;

    int errors = 0;
    int checks = 0;

    subneg_run_ctrl_if #(.ADDR_W(5), .DATA_W(5)) bus ();

    subneg_run_ctrl #(.ADDR_W(5), .MEM_DEPTH(22), .DATA_W(5), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run_i),
        .step_i    (step_i),
        .halt_i    (halt_i),
        .bp_en_i   (bp_en_i),
        .bp_addr_i (bp_addr_i),
        .pc_i      (pc_q),
        .bus       (bus),
        .fetch_en_o(fetch_en),
        .read_en_o (read_en),
        .exec_en_o (exec_en),
        .running_o (running),
        .bp_hit_o  (bp_hit),
        .fault_o   (fault),
        .icount_o  (icount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_set)       pc_q <= pc_set_val;
        else if (exec_en) pc_q <= pc_q + 5'd1;
    end

    typedef struct {
        logic       run;
        logic       ld_v;
        logic [4:0] ld_a;
        logic [4:0] ld_d;
        logic [5:0] exp_out;   // {fetch, read, exec, running, ready, we}
        logic [7:0] exp_icnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] pc0);
        rst_n = 1'b0;
        run_i = 0; step_i = 0; halt_i = 0; bp_en_i = 0; bp_addr_i = 0;
        bus.load_valid_i = 0; bus.load_addr_i = 0; bus.load_data_i = 0;
        pc_set = 1'b1; pc_set_val = pc0;
        tick();
        tick();
        rst_n  = 1'b1;
        pc_set = 1'b0;
    endtask

    initial begin
        int n;
        int ex;
        //               run ld  addr   data    f r e run rdy we   icnt
        tbl[0]  = '{1'b0, 1'b1, 5'd3,  5'd19, 6'b000011, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 5'd25, 5'd7,  6'b000010, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 5'd4,  5'd1,  6'b000011, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b000010, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 5'd3,  5'd19, 6'b000100, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b100100, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b010100, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b001100, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b000100, 8'd1};
        tbl[9]  = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b100100, 8'd1};
        tbl[10] = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b010100, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 5'd0,  5'd0,  6'b001100, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 5'd0,  5'd0,  6'b000100, 8'd2};
        tbl[13] = '{1'b0, 1'b0, 5'd0,  5'd0,  6'b000010, 8'd2};

        // ---- reset state and table-driven load / free-run ----
        do_reset(5'd0);
        chk("reset_status", {28'd0, running, bp_hit, fault, bus.load_ready_o}, 32'b0001);
        chk("reset_icount", icount, 0);
        for (int i = 0; i < 14; i++) begin
            run_i            = tbl[i].run;
            bus.load_valid_i = tbl[i].ld_v;
            bus.load_addr_i  = tbl[i].ld_a;
            bus.load_data_i  = tbl[i].ld_d;
            #1;
            chk($sformatf("vec%0d_out", i),
                {26'd0, fetch_en, read_en, exec_en, running, bus.load_ready_o, bus.mem_we_o},
                {26'd0, tbl[i].exp_out});
            chk($sformatf("vec%0d_icnt", i), icount, tbl[i].exp_icnt);
            if (i == 0) begin
                chk("load_addr", bus.mem_addr_o, 3);
                chk("load_data", bus.mem_wdata_o, 19);
            end
            tick();
        end
        bus.load_valid_i = 1'b0;

        // ---- single step from PC 0 ----
        do_reset(5'd0);
        step_i = 1'b1; tick(); step_i = 1'b0;
        chk("step_check", {29'd0, fetch_en, read_en, running}, 32'b001);
        tick(); chk("step_fetch", fetch_en, 1);
        tick(); chk("step_oper", read_en, 1);
        tick(); chk("step_exec", exec_en, 1);
        tick(); chk("step_recheck", {30'd0, running, fetch_en}, 32'b10);
        tick();
        chk("step_idle", {30'd0, running, bus.load_ready_o}, 32'b01);
        chk("step_icount", icount, 1);

        // ---- breakpoint at PC 9, run from PC 7 ----
        do_reset(5'd7);
        bp_en_i = 1'b1; bp_addr_i = 5'd9; run_i = 1'b1;
        tick();
        n = 0; ex = 0;
        while (running && n < 40) begin
            if (exec_en) ex++;
            tick();
            n++;
        end
        run_i = 1'b0;
        chk("bp_stopped", (n < 40), 1);
        chk("bp_execs", ex, 2);
        chk("bp_hit", bp_hit, 1);
        chk("bp_pc", pc_q, 9);
        chk("bp_icount", icount, 2);
        step_i = 1'b1; tick(); step_i = 1'b0;
        chk("bp_step_clear", {30'd0, running, bp_hit}, 32'b10);
        n = 0; ex = 0;
        while (running && n < 40) begin
            if (exec_en) ex++;
            tick();
            n++;
        end
        chk("bp_step_execs", ex, 1);
        chk("bp_step_pc", pc_q, 10);
        chk("bp_step_icount", icount, 3);
        chk("bp_step_hit", bp_hit, 0);
        bp_en_i = 1'b0;

        // ---- fault on out-of-range PC ----
        do_reset(5'd20);
        step_i = 1'b1; tick(); step_i = 1'b0;
        tick();
        chk("fault_set", {30'd0, fault, running}, 32'b10);
        run_i = 1'b1; step_i = 1'b1; tick(); step_i = 1'b0; tick(); tick();
        chk("fault_ignore_start", running, 0);
        chk("fault_icount", icount, 0);
        do_reset(5'd0);
        chk("fault_cleared", fault, 0);

        // ---- halt during OPER ----
        run_i = 1'b1;
        tick(); tick(); tick();
        chk("halt_in_oper", read_en, 1);
        halt_i = 1'b1; tick(); halt_i = 1'b0;
        chk("halt_exec_done", exec_en, 1);
        tick();
        chk("halt_check", {30'd0, running, fetch_en}, 32'b10);
        chk("halt_icount", icount, 1);
        tick();
        run_i = 1'b0;
        chk("halt_idle", running, 0);
        tick();
        chk("halt_stays_idle", running, 0);

        // ---- reset during EXEC ----
        do_reset(5'd0);
        run_i = 1'b1;
        tick(); tick(); tick(); tick();
        chk("rst_in_exec", exec_en, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_strobes", {29'd0, fetch_en, read_en, exec_en}, 0);
        chk("rst_running", running, 0);
        chk("rst_icount", icount, 0);
        run_i = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
